// File: rtl/apb_global_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_global_pkg
//  Purpose  : Shared types and defaults for the APB multi-slave interconnect.
//             - Default slave count and region size.
//             - Interconnect FSM state encoding.
//             - Slave index type sized for the default slave count.
//  Revision : 1.0  initial release
// ============================================================================
package apb_global_pkg;

    localparam int c_DEFAULT_NO_OF_SLAVES      = 4;
    localparam int c_DEFAULT_SLAVE_REGION_BITS = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DECERR = 2'd2,
        ABORT  = 2'd3
    } apb_ic_state_e;

    typedef logic [$clog2(c_DEFAULT_NO_OF_SLAVES)-1:0] slave_idx_t;

endpackage
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : apb_addr_decoder
//  Purpose  : Combinational address decode for the APB interconnect. Slaves
//             own contiguous 2**SLAVE_REGION_BITS byte regions starting at
//             SLAVE_BASE.
//  Ports    : i_paddr  - master address
//             i_pprot  - master protection attributes
//             o_hit    - address maps to an accessible slave
//             o_idx    - slave index (valid only when o_hit)
//             o_sel    - one-hot slave select (zero on a miss)
//  Options  : APB_PROT_CHECK_EN - non-secure (pprot[1]=1) accesses to slaves
//             flagged in SECURE_SLAVE_MASK are reported as misses.
//  Revision : 1.0  initial release
// ============================================================================
module apb_addr_decoder
    import apb_global_pkg::*;
#(
    parameter int                        ADDRESS_WIDTH     = 32,
    parameter int                        NO_OF_SLAVES      = c_DEFAULT_NO_OF_SLAVES,
    parameter logic [ADDRESS_WIDTH-1:0]  SLAVE_BASE        = '0,
    parameter int                        SLAVE_REGION_BITS = c_DEFAULT_SLAVE_REGION_BITS,
    parameter logic [NO_OF_SLAVES-1:0]   SECURE_SLAVE_MASK = '0,
    parameter int                        IDX_W             = 2
) (
    input  logic [ADDRESS_WIDTH-1:0] i_paddr,
    input  logic [2:0]               i_pprot,
    output logic                     o_hit,
    output logic [IDX_W-1:0]         o_idx,
    output logic [NO_OF_SLAVES-1:0]  o_sel
);

    localparam logic [ADDRESS_WIDTH-1:0] c_SLAVE_COUNT = ADDRESS_WIDTH'(NO_OF_SLAVES);

    logic [ADDRESS_WIDTH-1:0] w_offset;
    logic [ADDRESS_WIDTH-1:0] w_region;
    logic                     w_in_range;
    logic                     w_blocked;

    assign w_offset   = i_paddr - SLAVE_BASE;
    assign w_region   = w_offset >> SLAVE_REGION_BITS;
    // Below-base addresses wrap to large offsets, hence the explicit >= test.
    assign w_in_range = (i_paddr >= SLAVE_BASE) && (w_region < c_SLAVE_COUNT);
    assign o_idx      = w_region[IDX_W-1:0];

`ifdef APB_PROT_CHECK_EN
    logic w_unused_pprot;
    assign w_unused_pprot = i_pprot[0] ^ i_pprot[2];
    assign w_blocked      = i_pprot[1] && SECURE_SLAVE_MASK[o_idx];
`else
    logic w_unused_pprot;
    assign w_unused_pprot = ^{i_pprot, SECURE_SLAVE_MASK};
    assign w_blocked      = 1'b0;
`endif

    assign o_hit = w_in_range && !w_blocked;
    assign o_sel = o_hit ? (NO_OF_SLAVES'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/apb_multi_slave_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : apb_multi_slave_interconnect
//  Purpose  : One APB master fanned out to NO_OF_SLAVES APB slaves. Adds
//             decode-error responses for unmapped addresses and aborts
//             slaves that hold pready low for TIMEOUT_CYCLES access cycles.
//  Ports    : pclk/preset         - clock, synchronous active-high reset
//             m_*                 - master-side APB port
//             s_psel              - one-hot slave select
//             s_penable, s_paddr, s_pwrite, s_pstrb, s_pwdata, s_pprot
//                                 - broadcast copies to all slaves
//             s_pready/s_prdata/s_pslverr - per-slave responses
//  Options  : APB_PROT_CHECK_EN - enables the secure-slave pprot check in
//             the address decoder.
//  Revision : 1.0  initial release
// ============================================================================
module apb_multi_slave_interconnect
    import apb_global_pkg::*;
#(
    parameter int                        ADDRESS_WIDTH     = 32,
    parameter int                        DATA_WIDTH        = 32,
    parameter int                        NO_OF_SLAVES      = c_DEFAULT_NO_OF_SLAVES,
    parameter logic [ADDRESS_WIDTH-1:0]  SLAVE_BASE        = '0,
    parameter int                        SLAVE_REGION_BITS = c_DEFAULT_SLAVE_REGION_BITS,
    parameter int                        TIMEOUT_CYCLES    = 16,
    parameter logic [NO_OF_SLAVES-1:0]   SECURE_SLAVE_MASK = '0
) (
    input  logic                               pclk,
    input  logic                               preset,
    input  logic                               m_psel,
    input  logic                               m_penable,
    input  logic [ADDRESS_WIDTH-1:0]           m_paddr,
    input  logic                               m_pwrite,
    input  logic [DATA_WIDTH/8-1:0]            m_pstrb,
    input  logic [DATA_WIDTH-1:0]              m_pwdata,
    input  logic [2:0]                         m_pprot,
    output logic                               m_pready,
    output logic [DATA_WIDTH-1:0]              m_prdata,
    output logic                               m_pslverr,
    output logic [NO_OF_SLAVES-1:0]            s_psel,
    output logic                               s_penable,
    output logic [ADDRESS_WIDTH-1:0]           s_paddr,
    output logic                               s_pwrite,
    output logic [DATA_WIDTH/8-1:0]            s_pstrb,
    output logic [DATA_WIDTH-1:0]              s_pwdata,
    output logic [2:0]                         s_pprot,
    input  logic [NO_OF_SLAVES-1:0]            s_pready,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] s_prdata,
    input  logic [NO_OF_SLAVES-1:0]            s_pslverr
);

    localparam int c_IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    apb_ic_state_e               r_state;
    apb_ic_state_e               w_state_next;
    logic [c_IDX_W-1:0]          r_sel;
    logic [c_IDX_W-1:0]          w_sel_next;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_CNT_W-1:0]          w_cnt_next;

    logic                        w_dec_hit;
    logic [c_IDX_W-1:0]          w_dec_idx;
    logic [NO_OF_SLAVES-1:0]     w_dec_sel;

    logic [NO_OF_SLAVES-1:0]     w_psel;
    logic                        w_penable;
    logic                        w_pready;
    logic                        w_pslverr;
    logic [DATA_WIDTH-1:0]       w_prdata;
    logic                        w_setup;
    logic                        w_slv_ready;
    logic [DATA_WIDTH-1:0]       w_slave_rdata [NO_OF_SLAVES];

    generate
        for (genvar gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_rdata
            assign w_slave_rdata[gi] = s_prdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    apb_addr_decoder #(
        .ADDRESS_WIDTH     (ADDRESS_WIDTH),
        .NO_OF_SLAVES      (NO_OF_SLAVES),
        .SLAVE_BASE        (SLAVE_BASE),
        .SLAVE_REGION_BITS (SLAVE_REGION_BITS),
        .SECURE_SLAVE_MASK (SECURE_SLAVE_MASK),
        .IDX_W             (c_IDX_W)
    ) u_decoder (
        .i_paddr (m_paddr),
        .i_pprot (m_pprot),
        .o_hit   (w_dec_hit),
        .o_idx   (w_dec_idx),
        .o_sel   (w_dec_sel)
    );

    assign w_setup     = m_psel && !m_penable;
    assign w_slv_ready = s_pready[r_sel];

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        w_psel       = '0;
        w_penable    = 1'b0;
        w_pready     = 1'b0;
        w_pslverr    = 1'b0;
        w_prdata     = '0;
        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                // A lone penable without a preceding setup is ignored here.
                if (w_setup) begin
                    if (w_dec_hit) begin
                        w_psel       = w_dec_sel;
                        w_sel_next   = w_dec_idx;
                        w_state_next = ACCESS;
                    end else begin
                        w_state_next = DECERR;
                    end
                end
            end
            ACCESS: begin
                if (!m_psel) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_psel    = NO_OF_SLAVES'(1) << r_sel;
                    w_penable = m_penable;
                    w_pready  = w_slv_ready;
                    w_pslverr = s_pslverr[r_sel];
                    w_prdata  = w_slave_rdata[r_sel];
                    if (m_penable && w_slv_ready) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else if (!w_slv_ready) begin
                        if (r_cnt == c_CNT_LAST) begin
                            w_state_next = ABORT;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
            end
            DECERR: begin
                if (!m_psel) begin
                    w_state_next = IDLE;
                end else if (m_penable) begin
                    w_pready     = 1'b1;
                    w_pslverr    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            ABORT: begin
                // Slave already dropped; any late pready from it is not observed.
                w_pready     = 1'b1;
                w_pslverr    = 1'b1;
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Reset drops the transfer in the same cycle: slave deselected and no
    // response reaches the master even though the state register still holds.
    assign s_psel    = w_psel & {NO_OF_SLAVES{~preset}};
    assign s_penable = w_penable & ~preset;
    assign m_pready  = w_pready & ~preset;
    assign m_pslverr = w_pslverr & ~preset;
    assign m_prdata  = w_prdata & {DATA_WIDTH{~preset}};

    assign s_paddr  = m_paddr;
    assign s_pwrite = m_pwrite;
    assign s_pstrb  = m_pstrb;
    assign s_pwdata = m_pwdata;
    assign s_pprot  = m_pprot;

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_slave_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_multi_slave_interconnect
//  Purpose  : Directed bench for apb_multi_slave_interconnect: a table of
//             single transfers plus hand-written reset / protocol sequences.
//  Options  : APB_PROT_CHECK_EN selects the expected outcome of the
//             non-secure access to the secure slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_multi_slave_interconnect;

    logic        pclk = 1'b0;
    logic        preset;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;
    logic        m_pready, m_pslverr;
    logic [31:0] m_prdata;
    logic [3:0]  s_psel;
    logic        s_penable, s_pwrite;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0]  s_pstrb;
    logic [2:0]  s_pprot;
    logic [3:0]  s_pready;
    logic [127:0] s_prdata;
    logic [3:0]  s_pslverr;

    int n_chk = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    apb_multi_slave_interconnect #(
        .ADDRESS_WIDTH     (32),
        .DATA_WIDTH        (32),
        .NO_OF_SLAVES      (4),
        .SLAVE_BASE        (32'h0000_0000),
        .SLAVE_REGION_BITS (12),
        .TIMEOUT_CYCLES    (16),
        .SECURE_SLAVE_MASK (4'b0100)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_paddr   (m_paddr),
        .m_pwrite  (m_pwrite),
        .m_pstrb   (m_pstrb),
        .m_pwdata  (m_pwdata),
        .m_pprot   (m_pprot),
        .m_pready  (m_pready),
        .m_prdata  (m_prdata),
        .m_pslverr (m_pslverr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_paddr   (s_paddr),
        .s_pwrite  (s_pwrite),
        .s_pstrb   (s_pstrb),
        .s_pwdata  (s_pwdata),
        .s_pprot   (s_pprot),
        .s_pready  (s_pready),
        .s_prdata  (s_prdata),
        .s_pslverr (s_pslverr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  prot;
        int          n_wait;
        logic [3:0]  slverr;
        logic [3:0]  exp_sel;
        int          exp_waits;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_acc_sel;
        logic        exp_pen;
    } vec_t;

    localparam int c_NVEC = 12;
    vec_t vecs [c_NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer; n_wait = access cycles with slave pready low.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] prot,
                        input int n_wait,
                        output logic [3:0] setup_sel, output logic setup_rdy,
                        output logic [31:0] setup_paddr, output logic [3:0] acc_sel,
                        output logic acc_pen, output int waits, output logic err,
                        output logic [31:0] rdata, output logic done);
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_paddr = addr; m_pwrite = wr;
        m_pwdata = ~addr; m_pprot = prot; m_pstrb = 4'hF;
        s_pready = (n_wait == 0) ? 4'hF : 4'h0;
        @(negedge pclk);
        setup_sel = s_psel; setup_rdy = m_pready; setup_paddr = s_paddr;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        waits = 0; done = 1'b0; acc_sel = 4'h0; acc_pen = 1'b0; err = 1'b0; rdata = 32'h0;
        for (int k = 0; k < 40 && !done; k++) begin
            s_pready = (k >= n_wait) ? 4'hF : 4'h0;
            @(negedge pclk);
            if (k == 0) acc_pen = s_penable;
            if (m_pready) begin
                done = 1'b1; acc_sel = s_psel; err = m_pslverr; rdata = m_prdata;
            end else begin
                waits++;
                @(posedge pclk); #1;
            end
        end
        if (done) begin
            @(posedge pclk); #1;
        end
        m_psel = 1'b0; m_penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  setup_sel, acc_sel;
        logic        setup_rdy, acc_pen, err, done;
        logic [31:0] setup_paddr, rdata;
        int          waits;

        //           addr          wr    prot    wt  slverr   sel     wt  err   rdata          acc_sel pen
        vecs[0]  = '{32'h0000_1004, 1'b1, 3'b000, 0,   4'b1101, 4'b0010, 0,  1'b0, 32'h2222_2222, 4'b0010, 1'b1};
        vecs[1]  = '{32'h0000_3010, 1'b0, 3'b000, 3,   4'b0000, 4'b1000, 3,  1'b0, 32'hDEAD_BEEF, 4'b1000, 1'b1};
        vecs[2]  = '{32'h0000_5000, 1'b0, 3'b000, 0,   4'b1111, 4'b0000, 0,  1'b1, 32'h0000_0000, 4'b0000, 1'b0};
        vecs[3]  = '{32'h0000_0000, 1'b0, 3'b000, 0,   4'b0001, 4'b0001, 0,  1'b1, 32'h1111_1111, 4'b0001, 1'b1};
        vecs[4]  = '{32'h0000_2FFC, 1'b0, 3'b000, 1,   4'b1011, 4'b0100, 1,  1'b0, 32'h3333_3333, 4'b0100, 1'b1};
        vecs[5]  = '{32'h0000_3FFF, 1'b1, 3'b000, 0,   4'b0111, 4'b1000, 0,  1'b0, 32'hDEAD_BEEF, 4'b1000, 1'b1};
        vecs[6]  = '{32'h0000_4000, 1'b0, 3'b000, 0,   4'b0000, 4'b0000, 0,  1'b1, 32'h0000_0000, 4'b0000, 1'b0};
        vecs[7]  = '{32'h0000_2000, 1'b0, 3'b000, 255, 4'b0000, 4'b0100, 16, 1'b1, 32'h0000_0000, 4'b0000, 1'b1};
        vecs[8]  = '{32'h0000_0010, 1'b0, 3'b000, 0,   4'b1110, 4'b0001, 0,  1'b0, 32'h1111_1111, 4'b0001, 1'b1};
        vecs[9]  = '{32'hFFFF_F000, 1'b0, 3'b000, 0,   4'b0000, 4'b0000, 0,  1'b1, 32'h0000_0000, 4'b0000, 1'b0};
`ifdef APB_PROT_CHECK_EN
        vecs[10] = '{32'h0000_2000, 1'b0, 3'b010, 0,   4'b0000, 4'b0000, 0,  1'b1, 32'h0000_0000, 4'b0000, 1'b0};
`else
        vecs[10] = '{32'h0000_2000, 1'b0, 3'b010, 0,   4'b0000, 4'b0100, 0,  1'b0, 32'h3333_3333, 4'b0100, 1'b1};
`endif
        vecs[11] = '{32'h0000_2004, 1'b0, 3'b000, 0,   4'b0000, 4'b0100, 0,  1'b0, 32'h3333_3333, 4'b0100, 1'b1};

        preset = 1'b1; m_psel = 1'b0; m_penable = 1'b0; m_paddr = 32'h0;
        m_pwrite = 1'b0; m_pstrb = 4'h0; m_pwdata = 32'h0; m_pprot = 3'b000;
        s_pready = 4'hF; s_pslverr = 4'h0;
        s_prdata = {32'hDEAD_BEEF, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        // Reset state, during and on the cycle after reset.
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_psel", {28'h0, s_psel}, 32'h0);
        chk("rst_pready", {31'h0, m_pready}, 32'h0);
        chk("rst_pslverr", {31'h0, m_pslverr}, 32'h0);
        chk("rst_prdata", m_prdata, 32'h0);
        @(posedge pclk); #1 preset = 1'b0;
        @(negedge pclk);
        chk("post_rst_psel", {28'h0, s_psel}, 32'h0);
        chk("post_rst_penable", {31'h0, s_penable}, 32'h0);
        chk("post_rst_pready", {31'h0, m_pready}, 32'h0);

        // Table of single transfers.
        for (int i = 0; i < c_NVEC; i++) begin
            s_pslverr = vecs[i].slverr;
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].prot, vecs[i].n_wait,
                 setup_sel, setup_rdy, setup_paddr, acc_sel, acc_pen, waits, err, rdata, done);
            chk($sformatf("v%0d_setup_sel", i), {28'h0, setup_sel}, {28'h0, vecs[i].exp_sel});
            chk($sformatf("v%0d_setup_rdy", i), {31'h0, setup_rdy}, 32'h0);
            chk($sformatf("v%0d_paddr", i), setup_paddr, vecs[i].addr);
            chk($sformatf("v%0d_penable", i), {31'h0, acc_pen}, {31'h0, vecs[i].exp_pen});
            chk($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
            chk($sformatf("v%0d_waits", i), waits, vecs[i].exp_waits);
            chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_acc_sel", i), {28'h0, acc_sel}, {28'h0, vecs[i].exp_acc_sel});
        end
        s_pslverr = 4'h0;

        // penable without a prior setup is ignored.
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b1; m_paddr = 32'h0000_1000;
        @(negedge pclk);
        chk("nosetup_psel0", {28'h0, s_psel}, 32'h0);
        chk("nosetup_rdy0", {31'h0, m_pready}, 32'h0);
        @(negedge pclk);
        chk("nosetup_psel1", {28'h0, s_psel}, 32'h0);
        chk("nosetup_rdy1", {31'h0, m_pready}, 32'h0);
        @(posedge pclk); #1;
        m_psel = 1'b0; m_penable = 1'b0;

        // psel dropped mid-ACCESS returns to IDLE silently.
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0000_1000; s_pready = 4'h0;
        @(negedge pclk);
        chk("drop_setup_sel", {28'h0, s_psel}, 32'h2);
        @(posedge pclk); #1 m_penable = 1'b1;
        @(negedge pclk);
        chk("drop_acc_sel", {28'h0, s_psel}, 32'h2);
        chk("drop_acc_rdy", {31'h0, m_pready}, 32'h0);
        @(posedge pclk); #1 m_psel = 1'b0; m_penable = 1'b0;
        @(negedge pclk);
        chk("drop_sel", {28'h0, s_psel}, 32'h0);
        chk("drop_rdy", {31'h0, m_pready}, 32'h0);
        xfer(32'h0000_1008, 1'b0, 3'b000, 0, setup_sel, setup_rdy, setup_paddr,
             acc_sel, acc_pen, waits, err, rdata, done);
        chk("drop_next_sel", {28'h0, setup_sel}, 32'h2);
        chk("drop_next_rdata", rdata, 32'h2222_2222);

        // Reset during ACCESS to slave 0.
        @(posedge pclk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0000_0000; s_pready = 4'h0;
        @(posedge pclk); #1 m_penable = 1'b1;
        @(negedge pclk);
        chk("rstmid_acc_sel", {28'h0, s_psel}, 32'h1);
        @(posedge pclk); #1 preset = 1'b1; s_pready = 4'hF;
        @(negedge pclk);
        chk("rstmid_sel", {28'h0, s_psel}, 32'h0);
        chk("rstmid_penable", {31'h0, s_penable}, 32'h0);
        chk("rstmid_rdy", {31'h0, m_pready}, 32'h0);
        @(posedge pclk); #1 preset = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
        @(negedge pclk);
        chk("rstmid_after_sel", {28'h0, s_psel}, 32'h0);
        chk("rstmid_after_rdy", {31'h0, m_pready}, 32'h0);
        chk("rstmid_after_err", {31'h0, m_pslverr}, 32'h0);
        chk("rstmid_after_rdata", m_prdata, 32'h0);
        xfer(32'h0000_0004, 1'b0, 3'b000, 0, setup_sel, setup_rdy, setup_paddr,
             acc_sel, acc_pen, waits, err, rdata, done);
        chk("rstmid_next_done", {31'h0, done}, 32'h1);
        chk("rstmid_next_sel", {28'h0, setup_sel}, 32'h1);
        chk("rstmid_next_rdata", rdata, 32'h1111_1111);
        chk("rstmid_next_err", {31'h0, err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_multi_slave_interconnect.md
Name: apb_multi_slave_interconnect

Overview:
- Parametrised APB interconnect: one APB master port fanned out to NO_OF_SLAVES APB slave ports, selected by address decode.
- Successor to the single-point APB pin bundle. It adds:
  - multi-slave routing;
  - decode-error response for unmapped addresses;
  - a wait-state timeout that aborts hung slaves.
- Sits between the master agent/DUT bus and slave agents in hdl_top.

Parameters:
- ADDRESS_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width (multiple of 8).
- NO_OF_SLAVES, 4, slave port count (1..16).
- SLAVE_BASE, 32'h0000_0000, base address of slave 0.
- SLAVE_REGION_BITS, 12, each slave owns 2**SLAVE_REGION_BITS bytes, contiguous from SLAVE_BASE.
- TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort (>=2).
- SECURE_SLAVE_MASK, 0, bit i=1 marks slave i secure (used only with optional feature).

Ports:
- pclk  input  1  APB clock.
- preset  input  1  synchronous active-high reset.
- m_psel  input  1  master select.
- m_penable  input  1  master enable.
- m_paddr  input  ADDRESS_WIDTH  master address.
- m_pwrite  input  1  master write/read.
- m_pstrb  input  DATA_WIDTH/8  write strobes.
- m_pwdata  input  DATA_WIDTH  write data.
- m_pprot  input  3  protection.
- m_pready  output  1  ready to master.
- m_prdata  output  DATA_WIDTH  read data to master.
- m_pslverr  output  1  error to master.
- s_psel  output  NO_OF_SLAVES  one-hot slave select.
- s_penable  output  1  broadcast enable.
- s_paddr/s_pwrite/s_pstrb/s_pwdata/s_pprot  output  as master  broadcast copies of master signals.
- s_pready  input  NO_OF_SLAVES  per-slave ready.
- s_prdata  input  NO_OF_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_pslverr  input  NO_OF_SLAVES  per-slave error.

Behaviour:
- Reset: one clock pclk; reset preset is synchronous and active-high. While preset=1 and on the cycle after:
  - FSM=IDLE;
  - s_psel=0, s_penable=0;
  - m_pready=0, m_pslverr=0, m_prdata=0;
  - timeout counter=0.
- Reset mid-transfer: the transfer is dropped and the slave is deselected in the same cycle (s_psel gated by !preset). No response is given to the master.
- FSM states: IDLE, ACCESS, DECERR, ABORT.
- IDLE:
  - Setup is detected when m_psel=1 and m_penable=0.
  - Decode is combinational: idx=(m_paddr-SLAVE_BASE)>>SLAVE_REGION_BITS. The address is a hit iff m_paddr>=SLAVE_BASE and idx<NO_OF_SLAVES.
  - On a hit: s_psel[idx]=1 in that same cycle (zero added latency). idx is registered into sel_q. Next state is ACCESS.
  - On a miss: no s_psel. Next state is DECERR.
- ACCESS:
  - s_psel[sel_q]=1 and s_penable=m_penable.
  - m_pready=s_pready[sel_q]; m_prdata=s_prdata[sel_q]; m_pslverr=s_pslverr[sel_q] (combinational pass-through).
  - When m_penable & s_pready[sel_q], go to IDLE. Back-to-back setup is accepted in the following cycle.
  - Counter increments each ACCESS cycle with s_pready[sel_q]=0. When it reaches TIMEOUT_CYCLES-1, next state is ABORT.
- ABORT:
  - One cycle; s_psel=0, s_penable=0.
  - m_pready=1, m_pslverr=1, m_prdata=0.
  - Next state is IDLE; the counter clears.
  - A late s_pready from the aborted slave is ignored.
- DECERR:
  - On the access cycle (m_penable=1): m_pready=1, m_pslverr=1, m_prdata=0. Next state is IDLE.
- Outside ACCESS, DECERR and ABORT: m_pready=0, m_pslverr=0, m_prdata=0.
- Protocol violations:
  - m_penable=1 in IDLE without a prior setup is ignored (no select, no pready).
  - m_psel dropping in ACCESS or DECERR gives an immediate return to IDLE with no response.
- Broadcast signals (s_paddr etc.) are continuous copies of the master inputs.
- Reads of m_pslverr/m_prdata are valid only when m_pready=1.

Optional Feature:
- Macro: APB_PROT_CHECK_EN.
- Defined: a setup with m_pprot[1]=1 (non-secure) decoding to slave i with SECURE_SLAVE_MASK[i]=1 is treated as a miss. The slave is not selected and the DECERR response is given.
- Undefined: no pprot check. pprot is forwarded unchanged and SECURE_SLAVE_MASK is unused.

Decomposition:
- apb_global_pkg gains:
  - NO_OF_SLAVES and SLAVE_REGION_BITS defaults;
  - typedef enum logic [1:0] {IDLE, ACCESS, DECERR, ABORT} apb_ic_state_e;
  - typedef logic [$clog2(NO_OF_SLAVES)-1:0] slave_idx_t.
- One sub-module: apb_addr_decoder, combinational. It takes paddr and pprot and outputs hit, idx and one-hot select; the protection check lives there under the macro.

Test Plan:
- Write to 0x0000_1004 (slave 1), slave 1 pready on the first access cycle -> s_psel=4'b0010 in setup, m_pready=1 and m_pslverr=0 in the next cycle, 2-cycle transfer.
- Read from 0x0000_3010 with slave 3 holding pready low 3 cycles, prdata=32'hDEAD_BEEF -> m_pready low 3 cycles, then m_prdata=32'hDEAD_BEEF, m_pslverr=0.
- Access to 0x0000_5000 (unmapped, NO_OF_SLAVES=4) -> s_psel=0 throughout, access cycle m_pready=1, m_pslverr=1, m_prdata=0.
- Slave 2 never asserts pready, TIMEOUT_CYCLES=16 -> ABORT after 16 ACCESS cycles, m_pslverr=1, s_psel deasserted, the next transfer to slave 0 completes normally.
- preset asserted during the ACCESS phase to slave 0 -> s_psel=0 in the same cycle, all outputs 0 the next cycle, a fresh transfer after release succeeds.
- With APB_PROT_CHECK_EN and SECURE_SLAVE_MASK=4'b0100, read 0x0000_2000 with pprot=3'b010 -> DECERR (pslverr=1), slave 2 never selected; the same read with pprot=3'b000 completes normally.
